hpdl_bus_monitor: RTL and testbench
===================================

# hpdl_bus_monitor

Receiving end of the HPDL-1414 write bus: it snoops the D/A/WR lines that the display driver produces and rebuilds the 16-character display contents in a local buffer. Whenever a write changes that buffer, it sends a framed snapshot to the UART transmitter so the host can read back what is really on the displays. It sits beside or instead of the physical displays, on the same Pmod pins, and provides loop-back verification of the display path.

## Interface
- NUM_CHIPS, 4: number of HPDL-1414 devices (WR strobes); buffer holds 4*NUM_CHIPS characters
- SYNC_STAGES, 2: synchronizer depth for bus inputs (minimum 2)
- MIN_GAP, 12000: minimum CLK cycles from one frame's ETX transfer to the next frame's STX being offered
- CLK  in  1  system clock, 12 MHz
- RST  in  1  asynchronous, active-high reset
- hpdl_d  in  7  character data D6..D0, asynchronous to CLK
- hpdl_a  in  2  digit address A1..A0, asynchronous to CLK
- hpdl_wr_n  in  NUM_CHIPS  active-low write strobes, bit k = chip k
- tx_data  out  8  byte offered to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter can accept; tied to ~TxD_busy
- frame_count  out  16  frames fully sent, wraps
- conflict_count  out  8  writes rejected due to multiple strobes, saturates at 255

## Operation
- All hpdl_* inputs pass through SYNC_STAGES flops. A one-cycle-delayed copy of the synchronized bus is kept.
- Write event: a synchronized hpdl_wr_n bit rises (delayed value 0, current value 1). Data and address come from the delayed copy, which is the value present while WR was low.
- Slot index = k*4 + hpdl_a, range 0..4*NUM_CHIPS-1. The stored byte is {1'b0, hpdl_d}, written raw with no character-set check.
- If two or more strobes rise in the same cycle, or any other strobe is low when one rises, the write is dropped and conflict_count increments.
- dirty is set only when a write changes the stored byte. Rewriting identical data (the normal refresh scan) does not set dirty.
- FSM states:
  - IDLE: go to STX when dirty and gap counter ≥ MIN_GAP.
  - STX: snapshot the whole buffer into a shadow copy, clear dirty in the same cycle, offer 0x02.
  - CHARS: offer shadow[0..N-1] in order.
  - ETX: offer 0x03. On transfer, increment frame_count, clear the gap counter, return to IDLE.
- Buffer updates during a frame do not alter the shadow. They set dirty again, so another frame follows after MIN_GAP.
- Frame length = 4*NUM_CHIPS + 2 bytes (18 at default).

## Timing
- Reset values:
  - buffer: all 0x20
  - dirty: 0
  - state: IDLE
  - tx_valid: 0
  - tx_data: 0x00
  - both counters: 0
  - gap counter: MIN_GAP, so the first frame is not delayed
  - synchronizers: WR flops 1, other flops 0
- Reset asserted mid-frame aborts immediately: tx_valid drops asynchronously and no partial ETX is sent.
- Pin WR rise to buffer update: SYNC_STAGES+1 CLK edges.
- dirty set to tx_valid high: 1 cycle if the gap has elapsed.
- Handshake: a transfer happens on a CLK edge where tx_valid && tx_ready. tx_data is stable while tx_valid is high and unaccepted. After a transfer, the next byte may be offered on the following cycle. tx_valid never drops without a transfer, except on reset.
- Gap counter saturates at MIN_GAP.
- Write and snapshot in the same cycle: the snapshot takes the pre-write buffer and dirty stays set.
- WR pulses shorter than 2 CLK periods are not guaranteed to be captured. The driver's pulses are far longer.

## Structure
- Package hpdl_pkg holds:
  - constants HPDL_STX = 8'h02, HPDL_ETX = 8'h03, HPDL_BLANK = 8'h20
  - function for frame length
  - FSM state enum {IDLE, STX, CHARS, ETX}
- One sub-module: hpdl_sync, a parameterized-width, SYNC_STAGES-deep synchronizer bank with per-bit reset value. It is instantiated once for the D/A/WR bundle.

## Test plan
- Reset, then write chip 0 addr 0 = 0x41, tx_ready=1 → frame 02, 41, fifteen 20s, 03; frame_count = 1.
- Write chip 3 addr 2 = 0x5A, then repeat the same write 10× → exactly one frame, slot 14 = 5A, no second frame.
- Hold tx_ready=0 for 50 cycles after STX is offered → tx_valid and tx_data = 02 are held steady, and the byte is sent once when ready rises.
- Mid-frame, write slot 5 = 0x30 → current frame shows the old slot 5. A second frame with 30 starts no earlier than MIN_GAP cycles after the first ETX.
- Drop hpdl_wr_n[0] and hpdl_wr_n[1] together, then release → buffer unchanged, conflict_count = 1, no frame.
- Assert RST during CHARS byte 7 → tx_valid = 0 at once, buffer all 20. After release, no frame until a new changing write.

Source files
------------

// File: rtl/hpdl_pkg.sv
// Shared constants, FSM state type and frame-length helper for the HPDL-1414 bus monitor.
package hpdl_pkg;

    localparam logic [7:0] HPDL_STX   = 8'h02;
    localparam logic [7:0] HPDL_ETX   = 8'h03;
    localparam logic [7:0] HPDL_BLANK = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STX   = 2'd1,
        CHARS = 2'd2,
        ETX   = 2'd3
    } hpdl_state_e;

    // STX + one byte per display character + ETX
    function automatic int hpdl_frame_len(input int num_chips);
        return 4 * num_chips + 2;
    endfunction

endpackage

// File: rtl/hpdl_bus_monitor_if.sv
// Snooped HPDL-1414 write bus plus the byte stream toward the UART transmitter.
interface hpdl_bus_monitor_if #(
    parameter int NUM_CHIPS = 4
);
    logic [6:0]           hpdl_d;
    logic [1:0]           hpdl_a;
    logic [NUM_CHIPS-1:0] hpdl_wr_n;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output hpdl_d, hpdl_a, hpdl_wr_n, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  hpdl_d, hpdl_a, hpdl_wr_n, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/hpdl_sync.sv
// Multi-stage synchronizer bank for asynchronous inputs, with a per-bit reset value.
module hpdl_sync #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [WIDTH-1:0] stage_r [DEPTH];

    // shift chain; reset value keeps strobes inactive until real bus activity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RESET_VAL;
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/hpdl_bus_monitor.sv
// Rebuilds the HPDL-1414 display contents from the snooped write bus and streams
// a framed snapshot (STX, characters, ETX) to the UART whenever the contents change.
module hpdl_bus_monitor
    import hpdl_pkg::*;
#(
    parameter int NUM_CHIPS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_GAP     = 12000
) (
    input  logic                clk,
    input  logic                rst,
    hpdl_bus_monitor_if.slave   bus,
    output logic [15:0]         frame_count,
    output logic [7:0]          conflict_count
);

    localparam int NSLOT     = 4 * NUM_CHIPS;
    localparam int FRAME_LEN = hpdl_frame_len(NUM_CHIPS);
    localparam int KW        = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
    localparam int SW        = KW + 2;
    localparam int BW        = 9 + NUM_CHIPS;
    localparam int GW        = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    localparam logic [GW-1:0] GAP_MAX   = GW'(MIN_GAP);
    localparam logic [SW-1:0] LAST_IDX  = SW'(FRAME_LEN - 3);
    localparam logic [BW-1:0] SYNC_INIT = {{NUM_CHIPS{1'b1}}, 9'd0};

    logic [BW-1:0]        bus_sync_s;
    logic [BW-1:0]        bus_prev_r;
    logic [NUM_CHIPS-1:0] wr_cur_s;
    logic [NUM_CHIPS-1:0] wr_prev_s;
    logic [6:0]           d_prev_s;
    logic [1:0]           a_prev_s;

    logic [NUM_CHIPS-1:0] rise_s;
    logic [KW-1:0]        chip_s;
    logic [SW-1:0]        slot_s;
    logic [7:0]           new_byte_s;
    logic                 wr_ok_s;
    logic                 conflict_s;
    logic                 changes_s;
    logic                 gap_done_s;
    logic                 snap_s;
    logic                 xfer_s;

    logic [7:0]           char_buf_r [NSLOT];
    logic [7:0]           shadow_r   [NSLOT];
    logic                 dirty_r;
    logic [7:0]           conflict_r;
    hpdl_state_e          state_r;
    logic [SW-1:0]        idx_r;
    logic [GW-1:0]        gap_r;
    logic [15:0]          frame_cnt_r;
    logic                 tx_valid_r;
    logic [7:0]           tx_data_r;

    hpdl_sync #(
        .WIDTH     (BW),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (SYNC_INIT)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  ({bus.hpdl_wr_n, bus.hpdl_a, bus.hpdl_d}),
        .dout (bus_sync_s)
    );

    // one-cycle-delayed copy: holds the D/A that were present while WR was still low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_prev_r <= SYNC_INIT;
        end else begin
            bus_prev_r <= bus_sync_s;
        end
    end

    assign wr_cur_s  = bus_sync_s[BW-1:9];
    assign wr_prev_s = bus_prev_r[BW-1:9];
    assign a_prev_s  = bus_prev_r[8:7];
    assign d_prev_s  = bus_prev_r[6:0];

    // write-event decode: exactly one rising strobe with every other strobe high
    always_comb begin
        rise_s = wr_cur_s & ~wr_prev_s;
        chip_s = '0;
        for (int k = 0; k < NUM_CHIPS; k++) begin
            chip_s = chip_s | (rise_s[k] ? KW'(k) : {KW{1'b0}});
        end
        slot_s     = {chip_s, a_prev_s};
        new_byte_s = {1'b0, d_prev_s};
        wr_ok_s    = $onehot(rise_s) && (&wr_cur_s);
        conflict_s = (|rise_s) && !wr_ok_s;
        changes_s  = wr_ok_s && (char_buf_r[slot_s] != new_byte_s);
    end

    assign gap_done_s = (gap_r >= GAP_MAX);
    assign snap_s     = (state_r == IDLE) && dirty_r && gap_done_s;
    assign xfer_s     = tx_valid_r && bus.tx_ready;

    // display buffer, change tracking and conflict counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                char_buf_r[i] <= HPDL_BLANK;
            end
            dirty_r    <= 1'b0;
            conflict_r <= 8'd0;
        end else begin
            if (wr_ok_s) begin
                char_buf_r[slot_s] <= new_byte_s;
            end
            // a changing write wins over the snapshot clear so the new data gets its own frame
            if (changes_s) begin
                dirty_r <= 1'b1;
            end else if (snap_s) begin
                dirty_r <= 1'b0;
            end
            if (conflict_s && (conflict_r != 8'hFF)) begin
                conflict_r <= conflict_r + 8'd1;
            end
        end
    end

    // frame sequencer with registered UART outputs and inter-frame gap timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            tx_valid_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            idx_r       <= '0;
            gap_r       <= GAP_MAX;
            frame_cnt_r <= 16'd0;
            for (int i = 0; i < NSLOT; i++) begin
                shadow_r[i] <= HPDL_BLANK;
            end
        end else begin
            if (gap_r != GAP_MAX) begin
                gap_r <= gap_r + GW'(1);
            end
            case (state_r)
                IDLE: begin
                    if (snap_s) begin
                        shadow_r   <= char_buf_r;
                        state_r    <= STX;
                        tx_valid_r <= 1'b1;
                        tx_data_r  <= HPDL_STX;
                    end
                end
                STX: begin
                    if (xfer_s) begin
                        state_r   <= CHARS;
                        idx_r     <= '0;
                        tx_data_r <= shadow_r[0];
                    end
                end
                CHARS: begin
                    if (xfer_s) begin
                        if (idx_r == LAST_IDX) begin
                            state_r   <= ETX;
                            tx_data_r <= HPDL_ETX;
                        end else begin
                            idx_r     <= idx_r + SW'(1);
                            tx_data_r <= shadow_r[idx_r + SW'(1)];
                        end
                    end
                end
                ETX: begin
                    if (xfer_s) begin
                        state_r     <= IDLE;
                        tx_valid_r  <= 1'b0;
                        frame_cnt_r <= frame_cnt_r + 16'd1;
                        gap_r       <= '0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    tx_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_valid   = tx_valid_r;
    assign bus.tx_data    = tx_data_r;
    assign frame_count    = frame_cnt_r;
    assign conflict_count = conflict_r;

endmodule

// File: tb/tb_hpdl_bus_monitor.sv
// Randomized self-checking bench: drives HPDL write pulses and compares received UART frames
// against a display-contents model kept as a plain byte array.
module tb_hpdl_bus_monitor;

    localparam int NUM_CHIPS   = 4;
    localparam int SYNC_STAGES = 2;
    localparam int MIN_GAP     = 300;
    localparam int NSLOT       = 4 * NUM_CHIPS;
    localparam int FLEN        = NSLOT + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] frame_count;
    logic [7:0]  conflict_count;

    always #5 clk = ~clk;

    hpdl_bus_monitor_if #(.NUM_CHIPS(NUM_CHIPS)) bus ();

    hpdl_bus_monitor #(
        .NUM_CHIPS   (NUM_CHIPS),
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_GAP     (MIN_GAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .frame_count    (frame_count),
        .conflict_count (conflict_count)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  model_buf [NSLOT];
    logic [7:0]  exp_snap  [NSLOT];
    logic [7:0]  frm       [FLEN];
    int          model_frames = 0;
    int          model_conflicts = 0;
    bit          rand_ready = 1'b0;

    logic [7:0]  rx_q [$];
    longint      cyc = 0;
    longint      last_etx_cyc = 0;
    longint      stx_offer_cyc = 0;
    int          stab_viol = 0;
    logic        prev_pend = 1'b0;
    logic        prev_valid = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    // receiver side: collect transferred bytes and watch handshake stability
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            prev_pend  <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            if (prev_pend && (!bus.tx_valid || bus.tx_data !== prev_data))
                stab_viol <= stab_viol + 1;
            if (bus.tx_valid && !prev_valid && bus.tx_data == 8'h02)
                stx_offer_cyc <= cyc;
            if (bus.tx_valid && bus.tx_ready) begin
                rx_q.push_back(bus.tx_data);
                if (bus.tx_data == 8'h03) last_etx_cyc <= cyc;
            end
            prev_pend  <= bus.tx_valid && !bus.tx_ready;
            prev_data  <= bus.tx_data;
            prev_valid <= bus.tx_valid;
        end
    end

    function automatic logic [7:0] exp_byte(input int i);
        if (i == 0) return 8'h02;
        else if (i == FLEN - 1) return 8'h03;
        else return exp_snap[i-1];
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_write(input int chip, input int addr, input logic [6:0] data, output bit changed);
        int slot;
        slot = chip * 4 + addr;
        bus.hpdl_d = data;
        bus.hpdl_a = addr[1:0];
        tick(2);
        bus.hpdl_wr_n[chip] = 1'b0;
        tick(4);
        bus.hpdl_wr_n[chip] = 1'b1;
        tick(5);
        changed = (model_buf[slot] != {1'b0, data});
        model_buf[slot] = {1'b0, data};
    endtask

    task automatic pick_change(input int avoid_slot, output int chip, output int addr, output logic [6:0] data);
        int slot;
        slot = $urandom_range(0, NSLOT - 1);
        if (slot == avoid_slot) slot = (slot + 1) % NSLOT;
        chip = slot / 4;
        addr = slot % 4;
        do data = 7'($urandom_range(33, 126));
        while ({1'b0, data} == model_buf[slot] || data == 7'h30);
    endtask

    task automatic collect_frame(input int budget, output bit got);
        int n = 0;
        while (rx_q.size() < FLEN && n < budget) begin
            tick(1);
            n++;
        end
        got = (rx_q.size() >= FLEN);
        for (int i = 0; i < FLEN; i++) frm[i] = got ? rx_q.pop_front() : 8'h00;
    endtask

    task automatic wait_valid(input int budget, output bit got);
        int n = 0;
        while (!bus.tx_valid && n < budget) begin
            tick(1);
            n++;
        end
        got = bus.tx_valid;
    endtask

    task automatic test_reset();
        bus.hpdl_d = 7'd0; bus.hpdl_a = 2'd0; bus.hpdl_wr_n = '1; bus.tx_ready = 1'b1;
        for (int i = 0; i < NSLOT; i++) model_buf[i] = 8'h20;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.tx_valid); end
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %02h want 00", bus.tx_data); end
        n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_frames: got %0d want 0", frame_count); end
        n_cmp++; if (conflict_count !== 8'd0) begin n_bad++; $display("FAIL reset_conflicts: got %0d want 0", conflict_count); end
        tick(50);
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL reset_quiet: got %0d bytes want 0", rx_q.size()); end
    endtask

    task automatic test_first_frame();
        bit ch, got;
        do_write(0, 0, 7'h41, ch);
        exp_snap = model_buf;
        collect_frame(MIN_GAP + 100, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL first_frame_arrive: got none want frame"); end
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (frm[i] !== exp_byte(i)) begin n_bad++; $display("FAIL first_frame byte %0d: got %02h want %02h", i, frm[i], exp_byte(i)); end
        end
        model_frames++;
        n_cmp++; if (frame_count !== 16'(model_frames)) begin n_bad++; $display("FAIL first_frame_count: got %0d want %0d", frame_count, model_frames); end
    endtask

    task automatic test_refresh();
        bit ch, got;
        do_write(3, 2, 7'h5A, ch);
        exp_snap = model_buf;
        for (int r = 0; r < 10; r++) do_write(3, 2, 7'h5A, ch);
        collect_frame(MIN_GAP + 300, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL refresh_arrive: got none want frame"); end
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (frm[i] !== exp_byte(i)) begin n_bad++; $display("FAIL refresh byte %0d: got %02h want %02h", i, frm[i], exp_byte(i)); end
        end
        n_cmp++; if (frm[15] !== 8'h5A) begin n_bad++; $display("FAIL refresh_slot14: got %02h want 5a", frm[15]); end
        model_frames++;
        tick(MIN_GAP + 100);
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL refresh_no_second: got %0d bytes want 0", rx_q.size()); end
        n_cmp++; if (frame_count !== 16'(model_frames)) begin n_bad++; $display("FAIL refresh_count: got %0d want %0d", frame_count, model_frames); end
    endtask

    task automatic test_backpressure();
        bit ch, got;
        int chip, addr, held_bad;
        logic [6:0] data;
        bus.tx_ready = 1'b0;
        pick_change(5, chip, addr, data);
        do_write(chip, addr, data, ch);
        exp_snap = model_buf;
        wait_valid(MIN_GAP + 100, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL bp_offer: got no tx_valid want 1"); end
        held_bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick(1);
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h02) held_bad++;
        end
        n_cmp++; if (held_bad != 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", held_bad); end
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL bp_no_xfer: got %0d bytes want 0", rx_q.size()); end
        bus.tx_ready = 1'b1;
        collect_frame(100, got);
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (frm[i] !== exp_byte(i)) begin n_bad++; $display("FAIL bp byte %0d: got %02h want %02h", i, frm[i], exp_byte(i)); end
        end
        model_frames++;
    endtask

    task automatic test_midframe();
        bit ch, got;
        int chip, addr;
        longint e1;
        logic [6:0] data;
        bus.tx_ready = 1'b0;
        pick_change(5, chip, addr, data);
        do_write(chip, addr, data, ch);
        wait_valid(MIN_GAP + 100, got);
        exp_snap = model_buf;
        do_write(1, 1, 7'h30, ch);
        bus.tx_ready = 1'b1;
        collect_frame(100, got);
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (frm[i] !== exp_byte(i)) begin n_bad++; $display("FAIL mid_old byte %0d: got %02h want %02h", i, frm[i], exp_byte(i)); end
        end
        model_frames++;
        tick(1);
        e1 = last_etx_cyc;
        exp_snap = model_buf;
        collect_frame(MIN_GAP + 200, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL mid_second_arrive: got none want frame"); end
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (frm[i] !== exp_byte(i)) begin n_bad++; $display("FAIL mid_new byte %0d: got %02h want %02h", i, frm[i], exp_byte(i)); end
        end
        model_frames++;
        n_cmp++; if (stx_offer_cyc - e1 < MIN_GAP) begin n_bad++; $display("FAIL mid_gap: got %0d cycles want >= %0d", stx_offer_cyc - e1, MIN_GAP); end
        n_cmp++; if (frame_count !== 16'(model_frames)) begin n_bad++; $display("FAIL mid_count: got %0d want %0d", frame_count, model_frames); end
    endtask

    task automatic test_random();
        bit ch, got;
        int chip, addr;
        logic [6:0] data;
        rand_ready = 1'b1;
        for (int it = 0; it < 8; it++) begin
            chip = $urandom_range(0, 1);
            addr = $urandom_range(0, 1);
            data = 7'($urandom_range(65, 67));
            do_write(chip, addr, data, ch);
            if (ch) begin
                exp_snap = model_buf;
                collect_frame(MIN_GAP + 400, got);
                n_cmp++; if (!got) begin n_bad++; $display("FAIL rand_arrive it %0d: got none want frame", it); end
                for (int i = 0; i < FLEN; i++) begin
                    n_cmp++; if (frm[i] !== exp_byte(i)) begin n_bad++; $display("FAIL rand it %0d byte %0d: got %02h want %02h", it, i, frm[i], exp_byte(i)); end
                end
                model_frames++;
            end else begin
                tick(MIN_GAP + 50);
                n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL rand_quiet it %0d: got %0d bytes want 0", it, rx_q.size()); end
            end
        end
        rand_ready = 1'b0;
        bus.tx_ready = 1'b1;
        tick(2);
        n_cmp++; if (frame_count !== 16'(model_frames)) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", frame_count, model_frames); end
    endtask

    task automatic test_conflict();
        bus.hpdl_d = 7'h55; bus.hpdl_a = 2'd0;
        tick(2);
        bus.hpdl_wr_n[0] = 1'b0; bus.hpdl_wr_n[1] = 1'b0;
        tick(4);
        bus.hpdl_wr_n[0] = 1'b1; bus.hpdl_wr_n[1] = 1'b1;
        tick(5);
        model_conflicts++;
        n_cmp++; if (conflict_count !== 8'(model_conflicts)) begin n_bad++; $display("FAIL conflict_count: got %0d want %0d", conflict_count, model_conflicts); end
        tick(MIN_GAP + 50);
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL conflict_no_frame: got %0d bytes want 0", rx_q.size()); end
        for (int r = 0; r < 300; r++) begin
            bus.hpdl_wr_n[2] = 1'b0; bus.hpdl_wr_n[3] = 1'b0;
            tick(3);
            bus.hpdl_wr_n[2] = 1'b1; bus.hpdl_wr_n[3] = 1'b1;
            tick(3);
            model_conflicts = (model_conflicts < 255) ? model_conflicts + 1 : 255;
        end
        tick(3);
        n_cmp++; if (conflict_count !== 8'(model_conflicts)) begin n_bad++; $display("FAIL conflict_saturate: got %0d want %0d", conflict_count, model_conflicts); end
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL conflict_sat_no_frame: got %0d bytes want 0", rx_q.size()); end
    endtask

    task automatic test_reset_midframe();
        bit ch, got;
        int chip, addr, n;
        logic [6:0] data;
        bus.tx_ready = 1'b1;
        pick_change(-1, chip, addr, data);
        do_write(chip, addr, data, ch);
        n = 0;
        while (rx_q.size() < 8 && n < MIN_GAP + 200) begin
            @(negedge clk);
            n++;
        end
        bus.tx_ready = 1'b0;
        n_cmp++; if (rx_q.size() != 8) begin n_bad++; $display("FAIL rst_mid_reach: got %0d bytes want 8", rx_q.size()); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_async: got %b want 0", bus.tx_valid); end
        tick(2);
        rst = 1'b0;
        rx_q.delete();
        for (int i = 0; i < NSLOT; i++) model_buf[i] = 8'h20;
        model_frames = 0;
        model_conflicts = 0;
        bus.tx_ready = 1'b1;
        tick(2);
        n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL rst_mid_frames: got %0d want 0", frame_count); end
        n_cmp++; if (conflict_count !== 8'd0) begin n_bad++; $display("FAIL rst_mid_conflicts: got %0d want 0", conflict_count); end
        tick(MIN_GAP + 50);
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL rst_mid_quiet: got %0d bytes want 0", rx_q.size()); end
        pick_change(-1, chip, addr, data);
        do_write(chip, addr, data, ch);
        exp_snap = model_buf;
        collect_frame(100, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL rst_mid_arrive: got none want frame"); end
        for (int i = 0; i < FLEN; i++) begin
            n_cmp++; if (frm[i] !== exp_byte(i)) begin n_bad++; $display("FAIL rst_mid byte %0d: got %02h want %02h", i, frm[i], exp_byte(i)); end
        end
        model_frames++;
        n_cmp++; if (frame_count !== 16'(model_frames)) begin n_bad++; $display("FAIL rst_mid_count: got %0d want %0d", frame_count, model_frames); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_refresh();
        test_backpressure();
        test_midframe();
        test_random();
        test_conflict();
        test_reset_midframe();
        n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL handshake_stability: got %0d violations want 0", stab_viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
